// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: writes each incoming pixel into a one-line RAM and
// pairs it with the same column of the previous line, one cycle later.
//
// state  | meaning
// IDLE   | waiting for a start-of-frame pixel; other pixels are dropped
// ACTIVE | inside a frame, counting columns and rows
module line_buffer_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic [15:0]              i_pixel,
  output logic                     o_ram_we,
  output logic [$clog2(WIDTH)-1:0] o_ram_waddr,
  output logic [$clog2(WIDTH)-1:0] o_ram_raddr,
  output logic [15:0]              o_ram_wdata,
  input  logic [15:0]              i_ram_rdata,
  output logic                     o_valid,
  output logic [15:0]              o_pix_cur,
  output logic [15:0]              o_pix_prev,
  output logic                     o_sol,
  output logic                     o_eol,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic                     o_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, pix_col;
  logic [RW-1:0] row_q, row_d, pix_row;
  logic          processed;
  logic          err_set;
  logic          prev_en_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    processed = 1'b0;
    err_set   = 1'b0;
    pix_col   = col_q;
    pix_row   = row_q;
    // a start-of-frame pixel always lands at the origin, even mid-frame
    if (i_valid && i_sof) begin
      pix_col = '0;
      pix_row = '0;
    end
    if (i_rst_n && i_valid) begin
      case (state_q)
        IDLE: begin
          if (i_sof) processed = 1'b1;
          else       err_set   = 1'b1;
        end
        ACTIVE: begin
          processed = 1'b1;
          err_set   = i_sof;
        end
        default: ;
      endcase
    end
    if (processed) begin
      state_d = ACTIVE;
      if (pix_col == COL_LAST) begin
        col_d = '0;
        if (pix_row == ROW_LAST) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = pix_row + 1'b1;
        end
      end else begin
        col_d = pix_col + 1'b1;
        row_d = pix_row;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      o_valid   <= 1'b0;
      o_pix_cur <= '0;
      prev_en_q <= 1'b0;
      o_sol     <= 1'b0;
      o_eol     <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      o_valid   <= processed;
      o_pix_cur <= i_pixel;
      prev_en_q <= processed && (pix_row != '0);
      o_sol     <= processed && (pix_col == '0);
      o_eol     <= processed && (pix_col == COL_LAST);
      o_sof     <= processed && (pix_col == '0) && (pix_row == '0);
      o_eof     <= processed && (pix_col == COL_LAST) && (pix_row == ROW_LAST);
      if (err_set) o_err <= 1'b1;
    end
  end

  // RAM read data arrives the cycle after the address, aligned with o_valid
  assign o_pix_prev  = prev_en_q ? i_ram_rdata : '0;
  assign o_ram_we    = processed;
  assign o_ram_waddr = pix_col;
  assign o_ram_raddr = pix_col;
  assign o_ram_wdata = i_pixel;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl (WIDTH=4, HEIGHT=3) with a read-before-write RAM
// and a frame-position model that predicts every output.
module tb_line_buffer_ctrl;
  localparam int W = 4;
  localparam int H = 3;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic [15:0] i_pixel = '0;
  logic        o_ram_we;
  logic [1:0]  o_ram_waddr, o_ram_raddr;
  logic [15:0] o_ram_wdata;
  logic [15:0] i_ram_rdata = '0;
  logic        o_valid;
  logic [15:0] o_pix_cur, o_pix_prev;
  logic        o_sol, o_eol, o_sof, o_eof, o_err;

  line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_pixel(i_pixel), .o_ram_we(o_ram_we), .o_ram_waddr(o_ram_waddr),
    .o_ram_raddr(o_ram_raddr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata), .o_valid(o_valid), .o_pix_cur(o_pix_cur),
    .o_pix_prev(o_pix_prev), .o_sol(o_sol), .o_eol(o_eol), .o_sof(o_sof),
    .o_eof(o_eof), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] ram [W];
  initial for (int i = 0; i < W; i++) ram[i] = '0;
  always @(posedge i_clk) begin
    i_ram_rdata <= ram[o_ram_raddr];
    if (o_ram_we) ram[o_ram_waddr] <= o_ram_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // model: frame position plus the last pixel seen in each column
  bit          m_active = 0;
  int          m_col = 0, m_row = 0;
  bit          e_err = 0, e_valid = 0, e_sol = 0, e_eol = 0, e_sof = 0, e_eof = 0;
  logic [15:0] e_cur = '0, e_prev = '0;
  logic [15:0] line_mem [W];
  initial for (int i = 0; i < W; i++) line_mem[i] = '0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_active = 0; m_col = 0; m_row = 0; e_err = 0;
      e_valid = 0; e_sol = 0; e_eol = 0; e_sof = 0; e_eof = 0;
      e_cur = '0; e_prev = '0;
    end else begin
      e_valid = 0; e_sol = 0; e_eol = 0; e_sof = 0; e_eof = 0;
      if (i_valid) begin
        if (i_sof) begin
          if (m_active) e_err = 1;
          m_active = 1; m_col = 0; m_row = 0;
        end
        if (!m_active) e_err = 1;
        else begin
          e_valid = 1;
          e_cur   = i_pixel;
          e_prev  = (m_row == 0) ? 16'h0 : line_mem[m_col];
          line_mem[m_col] = i_pixel;
          e_sol = (m_col == 0);
          e_eol = (m_col == W - 1);
          e_sof = (m_col == 0) && (m_row == 0);
          e_eof = (m_col == W - 1) && (m_row == H - 1);
          m_col++;
          if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) begin m_row = 0; m_active = 0; end
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [15:0] cur;
    logic [15:0] prev;
    logic sol, eol, sof, eof;
  } cap_t;
  cap_t cap[$];

  always @(negedge i_clk) begin
    bit we_exp;
    chk("o_valid", o_valid, e_valid);
    chk("o_err", o_err, e_err);
    if (e_valid) begin
      chk("o_pix_cur", o_pix_cur, e_cur);
      chk("o_pix_prev", o_pix_prev, e_prev);
      chk("flags", {o_sol, o_eol, o_sof, o_eof}, {e_sol, e_eol, e_sof, e_eof});
    end
    if (o_valid) cap.push_back('{o_pix_cur, o_pix_prev, o_sol, o_eol, o_sof, o_eof});
    we_exp = i_rst_n && i_valid && (i_sof || m_active);
    chk("o_ram_we", o_ram_we, we_exp);
    if (we_exp) begin
      chk("ram_waddr", o_ram_waddr, i_sof ? 0 : m_col);
      chk("ram_raddr", o_ram_raddr, i_sof ? 0 : m_col);
      chk("ram_wdata", o_ram_wdata, i_pixel);
    end
  end

  task automatic cyc(input bit v, input bit s, input logic [15:0] p);
    @(posedge i_clk);
    #1;
    i_valid = v; i_sof = s; i_pixel = p;
  endtask

  task automatic frame(input logic [15:0] base, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      cyc(1'b1, i == 0, base + 16'(i));
      if (gaps) cyc(1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    i_valid = 1'b1; i_sof = 1'b1; i_pixel = 16'h1234;
    #12;
    chk("rst_ram_we", o_ram_we, 0);
    chk("rst_outputs", {o_valid, o_sol, o_eol, o_sof, o_eof, o_err}, 0);
    chk("rst_pix", {o_pix_cur, o_pix_prev}, 0);
    i_valid = 1'b0; i_sof = 1'b0; i_pixel = '0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;

    cap.delete();
    frame(16'd0, 1'b0); idle(2);
    chk("f1_count", cap.size(), 12);
    if (cap.size() == 12) begin
      chk("f1_first", {cap[0].cur, cap[0].prev, cap[0].sof, cap[0].sol}, {16'd0, 16'd0, 2'b11});
      chk("f1_row0_prev", cap[3].prev, 0);
      chk("f1_row1_prev", cap[5].prev, 1);
      chk("f1_row1_last", {cap[7].prev, cap[7].eol}, {16'd3, 1'b1});
      chk("f1_row2_prev", cap[9].prev, 5);
      chk("f1_eof", {cap[11].cur, cap[11].prev, cap[11].eof}, {16'd11, 16'd7, 1'b1});
    end

    cap.delete();
    frame(16'd100, 1'b1); idle(2);
    chk("f2_count", cap.size(), 12);
    if (cap.size() == 12) begin
      chk("f2_row1_prev", cap[5].prev, 101);
      chk("f2_row2_prev", cap[10].prev, 106);
    end

    cap.delete();
    frame(16'd200, 1'b0); frame(16'd300, 1'b0); idle(2);
    chk("b2b_count", cap.size(), 24);
    if (cap.size() == 24) begin
      chk("b2b_sof", {cap[12].sof, cap[12].cur, cap[12].prev}, {1'b1, 16'd300, 16'd0});
      chk("b2b_row0_prev", cap[15].prev, 0);
      chk("b2b_row1_prev", cap[17].prev, 301);
      chk("b2b_row2_prev", cap[20].prev, 304);
    end
    chk("b2b_err", o_err, 0);

    cap.delete();
    cyc(1'b1, 1'b0, 16'hABCD);
    #1 chk("drop_ram_we", o_ram_we, 0);
    idle(3);
    chk("drop_count", cap.size(), 0);
    chk("drop_err", o_err, 1);

    #2 i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    chk("err_cleared", o_err, 0);

    cap.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, 16'(400 + i));
    for (int i = 0; i < W * H; i++) cyc(1'b1, i == 0, 16'(500 + i));
    idle(2);
    chk("rs_count", cap.size(), 18);
    if (cap.size() == 18) begin
      chk("rs_pixel", {cap[6].sof, cap[6].cur, cap[6].prev}, {1'b1, 16'd500, 16'd0});
      chk("rs_row1_prev", cap[11].prev, 501);
      chk("rs_eof", {cap[17].eof, cap[17].cur}, {1'b1, 16'd511});
    end
    chk("rs_err", o_err, 1);

    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 16'(600 + i));
    cyc(1'b1, 1'b0, 16'd605);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_outputs", {o_valid, o_sol, o_eol, o_sof, o_eof, o_err, o_ram_we}, 0);
    chk("arst_pix", {o_pix_cur, o_pix_prev}, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    cap.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'(606 + i));
    idle(2);
    chk("arst_dropped", cap.size(), 0);
    chk("arst_err", o_err, 1);

    cap.delete();
    frame(16'd700, 1'b0); idle(2);
    chk("post_count", cap.size(), 12);
    if (cap.size() == 12) begin
      chk("post_row0_prev", cap[1].prev, 0);
      chk("post_row1_prev", cap[4].prev, 700);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
